// File: rtl/ngy_grid_video_core.sv
// ngy_grid_video_core
// Display-side core of the snake game. It contains three parts:
//   * a programmable divider that generates the game-tick clock (clk_out);
//   * a 1-bit-per-cell grid frame buffer (single-port, registered read);
//   * a pixel driver that maps the scan position to a grid cell and
//     produces that cell's lit state two cycles later.
// Game logic owns the memory port whenever wr_en is high. During those
// cycles the video read is dropped and pixel_state holds its last value.

module ngy_grid_video_core #(
    parameter int DIVIDER     = 7400000,
    parameter int CELL_WIDTH  = 8,
    parameter int CELL_HEIGHT = 8,
    parameter int GRID_COLS   = 40,
    parameter int GRID_ROWS   = 30
) (
    input  logic        clk_74a,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  logic        wr_data,
    input  logic [9:0]  visible_x,
    input  logic [9:0]  visible_y,
    output logic        clk_out,
    output logic        pixel_state
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int RAM_LENGTH  = GRID_COLS * GRID_ROWS;
    localparam int HALF_PERIOD = DIVIDER / 2;
    localparam int CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(HALF_PERIOD - 1);

    // Comparison limits carry one spare bit so that a full-range input
    // never wraps when compared against them.
    localparam logic [11:0] RAM_LENGTH_W = 12'(RAM_LENGTH);
    localparam logic [10:0] X_LIMIT      = 11'(CELL_WIDTH * GRID_COLS);
    localparam logic [10:0] Y_LIMIT      = 11'(CELL_HEIGHT * GRID_ROWS);

    localparam logic [9:0]  CELL_W_V     = 10'(CELL_WIDTH);
    localparam logic [9:0]  CELL_H_V     = 10'(CELL_HEIGHT);
    localparam logic [10:0] COLS_V       = 11'(GRID_COLS);

    // ------------------------------------------------------------------
    // Game-tick clock divider
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] div_count_reg;

    // Count 0..HALF_PERIOD-1; wrap and toggle clk_out at the terminal count.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            div_count_reg <= '0;
            clk_out       <= 1'b0;
        end else if (div_count_reg == CNT_TERM) begin
            div_count_reg <= '0;
            clk_out       <= ~clk_out;
        end else begin
            div_count_reg <= div_count_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pixel driver: scan position -> cell address
    // ------------------------------------------------------------------
    logic [9:0]  cell_col;
    logic [9:0]  cell_row;
    logic [10:0] rd_addr;
    logic        in_grid;

    // Map the scan position onto a cell index. Constant divisors reduce to
    // shifts for power-of-two cell sizes. The row/column product is formed
    // in 11 bits, enough for every in-grid cell; out-of-grid positions may
    // alias, which is harmless because in_grid masks them downstream.
    always_comb begin
        cell_col = visible_x / CELL_W_V;
        cell_row = visible_y / CELL_H_V;
        rd_addr  = 11'(cell_row) * COLS_V + 11'(cell_col);
        in_grid  = ({1'b0, visible_x} < X_LIMIT) &&
                   ({1'b0, visible_y} < Y_LIMIT);
    end

    // ------------------------------------------------------------------
    // Grid frame buffer (single port, writer has priority)
    // ------------------------------------------------------------------
    // Contents power up cleared; reset deliberately leaves them alone so
    // that the playfield survives a core reset.
    logic        grid_mem [RAM_LENGTH] = '{default: 1'b0};
    logic [10:0] mem_addr;
    logic        mem_addr_in_range;
    logic        data_out_reg;

    // Single shared address: the writer takes the port whenever wr_en is set.
    always_comb begin
        mem_addr          = wr_en ? wr_addr : rd_addr;
        mem_addr_in_range = ({1'b0, mem_addr} < RAM_LENGTH_W);
    end

    // Array write; addresses beyond the last cell are discarded.
    always_ff @(posedge clk_74a) begin
        if (wr_en && mem_addr_in_range) begin
            grid_mem[mem_addr] <= wr_data;
        end
    end

    // Registered read; holds during writes, returns 0 beyond the last cell.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= 1'b0;
        end else if (!wr_en) begin
            data_out_reg <= mem_addr_in_range ? grid_mem[mem_addr] : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pixel driver output stage
    // ------------------------------------------------------------------
    logic rd_valid_reg;
    logic in_grid_d_reg;

    // Carry read-valid and grid-membership alongside the memory read.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_reg  <= 1'b0;
            in_grid_d_reg <= 1'b0;
        end else begin
            rd_valid_reg  <= ~wr_en;
            in_grid_d_reg <= in_grid;
        end
    end

    // Update the output only from valid reads; blank positions off the grid.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            pixel_state <= 1'b0;
        end else if (rd_valid_reg) begin
            pixel_state <= in_grid_d_reg ? data_out_reg : 1'b0;
        end
    end

endmodule

// File: tb/tb_ngy_grid_video_core.sv
// Directed self-checking bench for ngy_grid_video_core (DIVIDER = 4).
// Outputs are sampled 1 time unit after each rising edge; inputs are
// changed at the same point so they are stable well before the next edge.

module tb_ngy_grid_video_core;

    logic        clk_74a = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic        wr_data;
    logic [9:0]  visible_x;
    logic [9:0]  visible_y;
    logic        clk_out;
    logic        pixel_state;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic last_exp = 1'b0;

    always #5 clk_74a = ~clk_74a;

    ngy_grid_video_core #(
        .DIVIDER    (4),
        .CELL_WIDTH (8),
        .CELL_HEIGHT(8),
        .GRID_COLS  (40),
        .GRID_ROWS  (30)
    ) dut (
        .clk_74a    (clk_74a),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .visible_x  (visible_x),
        .visible_y  (visible_y),
        .clk_out    (clk_out),
        .pixel_state(pixel_state)
    );

    task automatic step();
        @(posedge clk_74a);
        #1;
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, observed, expected);
        end
    endtask

    task automatic write_cell(input logic [10:0] addr, input logic data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    // Present a position; the old value must still show after one edge,
    // the new cell's state after the second edge.
    task automatic scan(input logic [9:0] x, input logic [9:0] y,
                        input logic expected, input string tag);
        wr_en     = 1'b0;
        visible_x = x;
        visible_y = y;
        step();
        check({tag, "_lat1"}, pixel_state, last_exp);
        step();
        check(tag, pixel_state, expected);
        last_exp = expected;
    endtask

    task automatic clear_all();
        for (int a = 0; a < 1200; a++) begin
            write_cell(11'(a), 1'b0);
        end
    endtask

    initial begin
        logic [7:0] div_pat;
        div_pat   = 8'b0110_0110;
        reset_n   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = 1'b0;
        visible_x = '0;
        visible_y = '0;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_clk_out", clk_out, 1'b0);
        check("rst_pixel", pixel_state, 1'b0);

        // ---------------- divider: 2 low, 2 high ----------------
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("div_edge%0d", i + 1), clk_out, div_pat[i]);
        end
        step();
        check("div_edge9", clk_out, 1'b0);
        step();
        check("div_edge10", clk_out, 1'b1);
        step();
        check("div_edge11", clk_out, 1'b1);

        // Reset in the middle of the high phase clears immediately.
        reset_n = 1'b0;
        #1;
        check("div_async_rst", clk_out, 1'b0);
        step();
        check("div_rst_hold", clk_out, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("div_restart%0d", i + 1), clk_out, div_pat[i]);
        end
        last_exp = 1'b0;

        // ---------------- basic writes and reads ----------------
        clear_all();
        write_cell(11'd0, 1'b1);
        write_cell(11'd1199, 1'b1);
        scan(10'd0,   10'd0,   1'b1, "cell0_origin");
        scan(10'd7,   10'd7,   1'b1, "cell0_corner");
        scan(10'd8,   10'd0,   1'b0, "cell1_unlit");
        scan(10'd319, 10'd239, 1'b1, "cell1199");

        // ---------------- cell (20,15) = address 620 ----------------
        write_cell(11'd620, 1'b1);
        scan(10'd160, 10'd120, 1'b1, "c620_tl");
        scan(10'd167, 10'd127, 1'b1, "c620_br");
        scan(10'd163, 10'd124, 1'b1, "c620_mid");
        scan(10'd168, 10'd120, 1'b0, "c621_right");
        scan(10'd159, 10'd127, 1'b0, "c619_left");

        // ---------------- out-of-grid masking ----------------
        // (320,120) aliases to 640, (1023,0) to 127, (1023,1023) to 1111.
        write_cell(11'd640, 1'b1);
        write_cell(11'd127, 1'b1);
        write_cell(11'd1111, 1'b1);
        scan(10'd0,    10'd128,  1'b1, "c640_lit");
        scan(10'd320,  10'd120,  1'b0, "x320_off");
        scan(10'd248,  10'd216,  1'b1, "c1111_lit");
        scan(10'd1023, 10'd0,    1'b0, "x1023_off");
        scan(10'd160,  10'd240,  1'b0, "y240_off");
        scan(10'd1023, 10'd1023, 1'b0, "xy1023_off");

        // Address 1200 is ignored and must not alias onto 176 (cell 16,4).
        write_cell(11'd1200, 1'b1);
        scan(10'd128, 10'd32, 1'b0, "no_alias176");

        // Write then read the same address on the next cycle.
        write_cell(11'd300, 1'b1);
        scan(10'd160, 10'd56, 1'b1, "wr_then_rd300");

        // ---------------- write steals the port: pixel holds ----------------
        scan(10'd160, 10'd120, 1'b1, "hold_pre");
        visible_x = 10'd8;
        visible_y = 10'd8;
        wr_en     = 1'b1;
        wr_addr   = 11'd500;
        wr_data   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_wr%0d", i + 1), pixel_state, 1'b1);
        end
        wr_en = 1'b0;
        step();
        check("hold_after1", pixel_state, 1'b1);
        step();
        check("hold_after2", pixel_state, 1'b0);
        last_exp = 1'b0;

        // ---------------- clear and sweep every cell ----------------
        clear_all();
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 40; c++) begin
                visible_x = 10'(c * 8 + (c % 8));
                visible_y = 10'(r * 8 + (r % 8));
                step();
                check($sformatf("sweep_r%0d_c%0d", r, c), pixel_state, 1'b0);
            end
        end
        last_exp = 1'b0;

        // ---------------- reset retains memory ----------------
        write_cell(11'd620, 1'b1);
        scan(10'd160, 10'd120, 1'b1, "pre_rst_lit");
        reset_n = 1'b0;
        #1;
        check("rst2_pixel", pixel_state, 1'b0);
        check("rst2_clk_out", clk_out, 1'b0);
        step();
        reset_n  = 1'b1;
        last_exp = 1'b0;
        scan(10'd160, 10'd120, 1'b1, "post_rst_retained");
        scan(10'd0,   10'd0,   1'b0, "post_rst_cleared0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
